// File: rtl/nn_dense_layer_if.sv
// nn_dense_layer_if
// Bundles the job-input and result-output handshakes of nn_dense_layer.
//   in_valid / in_ready   : job handshake. x_flat and w_flat are sampled on acceptance.
//   x_flat                : activation i at bits [i*W +: W]
//   w_flat                : weight i->j at bits [(j*N_IN+i)*W +: W]
//   out_valid / out_ready : result handshake, one neuron per transfer
//   out_data              : neuron result
//   out_idx               : neuron index j
//   out_last              : high with the result of neuron N_OUT-1
// The layer connects to the slave modport. The job source / result sink uses master.
interface nn_dense_layer_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int W     = 16
);
  localparam int IDXW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN*W-1:0]       x_flat;
  logic [N_IN*N_OUT*W-1:0] w_flat;
  logic                    out_valid;
  logic                    out_ready;
  logic [W-1:0]            out_data;
  logic [IDXW-1:0]         out_idx;
  logic                    out_last;

  modport master (
    output in_valid, x_flat, w_flat, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, x_flat, w_flat, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/nn_dense_layer.sv
// nn_dense_layer
// Time-multiplexed fully-connected layer. One job carries all activations and weights.
// A single signed MAC evaluates output neurons 0..N_OUT-1 in turn.
// Each neuron takes N_IN MAC cycles. Each result is held until it is accepted downstream.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset. It aborts any job in progress.
//   bus : nn_dense_layer_if.slave, carrying the job and result handshakes
// Parameters:
//   N_IN  : number of input activations
//   N_OUT : number of output neurons
//   W     : data width
//   FRAC  : arithmetic right shift applied to the accumulator before saturation
// Build option:
//   NN_RELU_EN : when defined, negative saturated results are clamped to zero (ReLU).
//                Otherwise the activation is linear.
module nn_dense_layer #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int W     = 16,
  parameter int FRAC  = 0
) (
  input logic             clk,
  input logic             rst,
  nn_dense_layer_if.slave bus
);

  localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int AW   = 2 * W + $clog2(N_IN);
  localparam int XW   = N_IN * W;
  localparam int WWID = N_IN * N_OUT * W;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [WWID-1:0]       w_q, w_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [IW-1:0]         i_q, i_d;
  logic [JW-1:0]         j_q, j_d;
  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          out_data_q, out_data_d;
  logic [JW-1:0]         out_idx_q, out_idx_d;
  logic                  out_last_q, out_last_d;

  logic signed [W-1:0]   xi, wi;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  sum, shifted;
  logic [W-1:0]          res;
  logic                  last_i, last_j;

  // Operand select for the current (i, j) term from the captured job.
  always_comb begin
    xi = '0;
    wi = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (i_q == IW'(k)) xi = x_q[k*W +: W];
    end
    for (int unsigned jj = 0; jj < N_OUT; jj++) begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (j_q == JW'(jj) && i_q == IW'(k)) wi = w_q[(jj*N_IN+k)*W +: W];
      end
    end
  end

  // The final result includes the term added on this cycle.
  // The shift is arithmetic (floor), and saturation is applied afterwards.
  always_comb begin
    prod    = xi * wi;
    sum     = acc_q + AW'(prod);
    shifted = sum >>> FRAC;
    if (shifted > SAT_MAX)      res = SAT_MAX[W-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[W-1:0];
    else                        res = shifted[W-1:0];
`ifdef NN_RELU_EN
    if (res[W-1]) res = '0;
`endif
  end

  assign last_i = (i_q == IW'(N_IN - 1));
  assign last_j = (j_q == JW'(N_OUT - 1));

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    w_d         = w_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.x_flat;
          w_d     = bus.w_flat;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = sum;
        i_d   = i_q + 1'b1;
        if (last_i) begin
          i_d         = '0;
          out_data_d  = res;
          out_idx_d   = j_q;
          out_last_d  = last_j;
          out_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (!last_j) begin
            j_d     = j_q + 1'b1;
            i_d     = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      w_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      w_q         <= w_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;

endmodule
